// File: rtl/ble_crc_pkg.sv
// Shared types and constants for the BLE CRC sequencer and its serial CRC-24 engine.
package ble_crc_pkg;

    typedef enum logic [1:0] {IDLE, PDU, CRC, DONE} crc_seq_state_t;

    localparam int CRC_W     = 24;
    localparam int CRC_IDX_W = 5;

    // x^24 + x^10 + x^9 + x^6 + x^4 + x^3 + x + 1, x^24 term implicit
    localparam logic [CRC_W-1:0] CRC_POLY = 24'h00065B;

    // One MSB-first LFSR step: feedback is the outgoing bit XOR the new data bit.
    function automatic logic [CRC_W-1:0] crc24_step(input logic [CRC_W-1:0] crc,
                                                    input logic din);
        logic fb;
        fb = crc[CRC_W-1] ^ din;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

endpackage

// File: rtl/serial_crc24.sv
// Bit-serial BLE CRC-24 engine: restart loads the preset, each valid input bit advances the LFSR.
module serial_crc24
    import ble_crc_pkg::*;
#(
    parameter logic [23:0] INIT_DEF = 24'h555555
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              restart,
    input  logic [CRC_W-1:0]  preset,
    input  logic              input_tvalid,
    input  logic              input_tdata,
    output logic [CRC_W-1:0]  crc_out
);

    logic [CRC_W-1:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (restart) begin
            crc_d = preset;
        end else if (input_tvalid) begin
            crc_d = crc24_step(crc_q, input_tdata);
        end
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            crc_q <= INIT_DEF;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/ble_crc_seq.sv
// BLE packet CRC sequencer: TX appends the CRC-24, RX checks the trailing 24 received bits.
// Optional RX error counter enabled by defining CRC_ERR_CNT_EN.
module ble_crc_seq
    import ble_crc_pkg::*;
#(
    parameter logic [23:0] CRC_INIT_DEF = 24'h555555,
    parameter int          CNT_WIDTH    = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 start,
    input  logic                 start_tx,
    input  logic                 start_use_def,
    input  logic [23:0]          crc_init,
    input  logic                 abort,
    input  logic                 s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    output logic                 m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 busy,
    output logic                 done,
    output logic                 crc_ok,
    output logic [CNT_WIDTH-1:0] err_count
);

    crc_seq_state_t        state_q, state_d;
    logic [CRC_IDX_W-1:0]  idx_q, idx_d;
    logic                  tx_q, tx_d;
    logic                  mismatch_q, mismatch_d;
    logic                  crc_ok_q, crc_ok_d;

    logic                  eng_restart;
    logic                  eng_valid;
    logic [CRC_W-1:0]      eng_preset;
    logic [CRC_W-1:0]      crc_out;
    logic                  result_ok;

    assign eng_restart = areset | ((state_q == IDLE) & start) | abort;
    assign eng_preset  = (areset | start_use_def) ? CRC_INIT_DEF : crc_init;
    assign result_ok   = tx_q | ~mismatch_q;

    serial_crc24 #(
        .INIT_DEF (CRC_INIT_DEF)
    ) u_crc (
        .aclk         (aclk),
        .aresetn      (~areset),
        .restart      (eng_restart),
        .preset       (eng_preset),
        .input_tvalid (eng_valid),
        .input_tdata  (s_axis_tdata),
        .crc_out      (crc_out)
    );

    // NOTE: every output and next-state is defaulted first so no path infers a latch.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        tx_d          = tx_q;
        mismatch_d    = mismatch_q;
        crc_ok_d      = crc_ok_q;
        eng_valid     = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tdata  = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        done          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tx_d       = start_tx;
                    mismatch_d = 1'b0;
                    crc_ok_d   = 1'b0;
                    state_d    = PDU;
                end
            end
            PDU: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                m_axis_tlast  = tx_q ? 1'b0 : s_axis_tlast;
                if (s_axis_tvalid && m_axis_tready) begin
                    eng_valid = 1'b1;
                    if (s_axis_tlast) begin
                        idx_d   = CRC_IDX_W'(CRC_W - 1);
                        state_d = CRC;
                    end
                end
            end
            CRC: begin
                // Engine is not advanced here, so crc_out[idx_q] is stable for the whole phase.
                if (tx_q) begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tdata  = crc_out[idx_q];
                    m_axis_tlast  = (idx_q == '0);
                    if (m_axis_tready) begin
                        if (idx_q == '0) state_d = DONE;
                        else             idx_d   = idx_q - CRC_IDX_W'(1);
                    end
                end else begin
                    s_axis_tready = 1'b1;
                    if (s_axis_tvalid) begin
                        mismatch_d = mismatch_q | (s_axis_tdata ^ crc_out[idx_q]);
                        if (idx_q == '0) state_d = DONE;
                        else             idx_d   = idx_q - CRC_IDX_W'(1);
                    end
                end
            end
            DONE: begin
                done     = 1'b1;
                crc_ok_d = result_ok;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides every transition and leaves the result registers untouched.
        if (abort) begin
            state_d    = IDLE;
            idx_d      = idx_q;
            tx_d       = tx_q;
            mismatch_d = mismatch_q;
            crc_ok_d   = crc_ok_q;
            eng_valid  = 1'b0;
            done       = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            tx_q       <= 1'b0;
            mismatch_q <= 1'b0;
            crc_ok_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_q       <= tx_d;
            mismatch_q <= mismatch_d;
            crc_ok_q   <= crc_ok_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign crc_ok = done ? result_ok : crc_ok_q;

`ifdef CRC_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (done && !tx_q && mismatch_q && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_ble_crc_seq.sv
// Scoreboard bench for ble_crc_seq: expected m-side beats queued at stimulus time, popped on transfer.
module tb_ble_crc_seq;

    logic        aclk = 1'b0;
    logic        areset;
    logic        start, start_tx, start_use_def;
    logic [23:0] crc_init;
    logic        abort;
    logic        s_tdata, s_tvalid, s_tready, s_tlast;
    logic        m_tdata, m_tvalid, m_tready, m_tlast;
    logic        busy, done, crc_ok;
    logic [15:0] err_count;

    typedef struct packed {
        logic d;
        logic l;
    } beat_t;

    beat_t       exp_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          out_count = 0;
    int          done_count = 0;
    logic        bp_en = 1'b0;
    logic [15:0] exp_err = '0;

    always #5 aclk = ~aclk;

    ble_crc_seq dut (
        .aclk          (aclk),
        .areset        (areset),
        .start         (start),
        .start_tx      (start_tx),
        .start_use_def (start_use_def),
        .crc_init      (crc_init),
        .abort         (abort),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .busy          (busy),
        .done          (done),
        .crc_ok        (crc_ok),
        .err_count     (err_count)
    );

    // Reference CRC: BLE polynomial, bits consumed MSB-first from bits[n-1] down to bits[0].
    function automatic logic [23:0] crc_model(input logic [23:0] init,
                                              input logic [31:0] bits, input int n);
        logic [23:0] c;
        logic        fb;
        c = init;
        for (int i = n - 1; i >= 0; i--) begin
            fb = c[23] ^ bits[i];
            c  = c << 1;
            if (fb) c = c ^ 24'h00065B;
        end
        return c;
    endfunction

    // m_axis_tready: constantly high, or toggling every cycle when bp_en is set.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            m_tready = bp_en ? ~m_tready : 1'b1;
        end
    end

    // Output monitor: every m-side transfer must match the head of the scoreboard.
    always @(negedge aclk) begin : monitor
        beat_t e;
        if (!areset && m_tvalid && m_tready) begin
            out_count++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_mis++;
                $display("FAIL m_beat_extra: got d=%0b last=%0b, required no beat", m_tdata, m_tlast);
            end else begin
                e = exp_q.pop_front();
                if ({m_tdata, m_tlast} !== {e.d, e.l}) begin
                    n_mis++;
                    $display("FAIL m_beat: got d=%0b last=%0b, required d=%0b last=%0b",
                             m_tdata, m_tlast, e.d, e.l);
                end
            end
        end
        if (!areset && done) done_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_beat(input logic d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        exp_q.push_back(b);
    endtask

    task automatic push_crc(input logic [23:0] c, input int nbits);
        for (int i = 23; i > 23 - nbits; i--) push_beat(c[i], (i == 0));
    endtask

    task automatic do_start(input logic tx, input logic use_def, input logic [23:0] init);
        start         = 1'b1;
        start_tx      = tx;
        start_use_def = use_def;
        crc_init      = init;
        @(posedge aclk);
        #1;
        start = 1'b0;
    endtask

    // Present one s-side bit and hold it until the handshake completes.
    task automatic drive_s(input logic d, input logic last);
        bit hs;
        bit ok;
        ok       = 1'b0;
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            hs = s_tready;
            @(posedge aclk);
            #1;
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_mis++;
            $display("FAIL s_handshake: s_axis_tready stayed 0 for 200 cycles, required 1");
        end
    endtask

    task automatic wait_done(input logic exp_ok, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge aclk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_mis++;
            $display("FAIL %s_done: done=0 for 400 cycles, required a pulse", name);
        end else begin
            n_cmp++;
            if (crc_ok !== exp_ok) begin
                n_mis++;
                $display("FAIL %s_crc_ok: got %0b, required %0b", name, crc_ok, exp_ok);
            end
            @(negedge aclk);
            n_cmp++;
            if (done !== 1'b0) begin
                n_mis++;
                $display("FAIL %s_done_width: done=%0b one cycle later, required 0", name, done);
            end
            n_cmp++;
            if (crc_ok !== exp_ok) begin
                n_mis++;
                $display("FAIL %s_crc_ok_hold: got %0b, required %0b", name, crc_ok, exp_ok);
            end
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL %s_drained: %0d beats still expected, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        n_cmp++;
        if ({busy, s_tready, m_tvalid, m_tlast, done, crc_ok} !== 6'b0 || err_count !== 16'd0) begin
            n_mis++;
            $display("FAIL %s: busy=%0b s_tready=%0b m_tvalid=%0b m_tlast=%0b done=%0b crc_ok=%0b err=%0d, required all 0",
                     name, busy, s_tready, m_tvalid, m_tlast, done, crc_ok, err_count);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check_idle_outputs("reset_in");
        areset = 1'b0;
        @(posedge aclk);
        #1;
        check_idle_outputs("reset_after");
    endtask

    task automatic test_tx_single();
        push_beat(1'b1, 1'b0);
        push_crc(24'h00065B, 24);
        do_start(1'b1, 1'b0, 24'h000000);
        drive_s(1'b1, 1'b1);
        wait_done(1'b1, "tx_single");
        check_drained("tx_single");
    endtask

    task automatic test_rx_single(input logic flip);
        logic [23:0] c;
        c = 24'h00065B ^ {23'b0, flip};
        push_beat(1'b1, 1'b1);
        do_start(1'b0, 1'b0, 24'h000000);
        drive_s(1'b1, 1'b1);
        for (int i = 23; i >= 0; i--) drive_s(c[i], 1'b0);
        wait_done(~flip, flip ? "rx_bad" : "rx_good");
        check_drained(flip ? "rx_bad" : "rx_good");
`ifdef CRC_ERR_CNT_EN
        if (flip) exp_err = exp_err + 16'd1;
`endif
        n_cmp++;
        if (err_count !== exp_err) begin
            n_mis++;
            $display("FAIL err_count: got %0d, required %0d", err_count, exp_err);
        end
    endtask

    task automatic test_back_pressure();
        logic [23:0] c;
        int          oc0;
        c = crc_model(24'h000000, 32'h0, 8);
        for (int i = 0; i < 8; i++) push_beat(1'b0, 1'b0);
        push_crc(c, 24);
        oc0   = out_count;
        bp_en = 1'b1;
        do_start(1'b1, 1'b0, 24'h000000);
        for (int i = 0; i < 8; i++) drive_s(1'b0, (i == 7));
        wait_done(1'b1, "bp");
        bp_en = 1'b0;
        n_cmp++;
        if (out_count - oc0 != 32) begin
            n_mis++;
            $display("FAIL bp_count: got %0d beats, required 32", out_count - oc0);
        end
        check_drained("bp");
        @(posedge aclk);
        #1;
    endtask

    task automatic test_abort();
        logic [23:0] c;
        logic [3:0]  pdu;
        logic [7:0]  pdu2;
        logic        ok_before;
        int          dc;
        pdu = 4'b1011;
        c   = crc_model(24'h555555, {28'b0, pdu}, 4);
        for (int i = 3; i >= 0; i--) push_beat(pdu[i], 1'b0);
        push_crc(c, 14);  // idx 23..10; idx 10 transfers in the abort cycle
        do_start(1'b1, 1'b1, 24'h000000);
        for (int i = 3; i >= 0; i--) drive_s(pdu[i], (i == 0));
        repeat (13) begin
            @(posedge aclk);
            #1;
        end
        ok_before = crc_ok;
        dc        = done_count;
        abort     = 1'b1;
        @(posedge aclk);
        #1;
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
            n_mis++;
            $display("FAIL abort_idle: busy=%0b m_tvalid=%0b, required 0 0", busy, m_tvalid);
        end
        repeat (5) @(posedge aclk);
        #1;
        n_cmp++;
        if (done_count != dc || crc_ok !== ok_before) begin
            n_mis++;
            $display("FAIL abort_no_done: done pulses=%0d crc_ok=%0b, required 0 and %0b",
                     done_count - dc, crc_ok, ok_before);
        end
        check_drained("abort");

        pdu2 = 8'hA5;
        c    = crc_model(24'h555555, {24'b0, pdu2}, 8);
        for (int i = 7; i >= 0; i--) push_beat(pdu2[i], 1'b0);
        push_crc(c, 24);
        do_start(1'b1, 1'b1, 24'h123456);
        for (int i = 7; i >= 0; i--) drive_s(pdu2[i], (i == 0));
        wait_done(1'b1, "post_abort");
        check_drained("post_abort");
    endtask

    task automatic test_start_busy_areset();
        push_beat(1'b1, 1'b0);
        push_beat(1'b0, 1'b0);
        push_beat(1'b1, 1'b1);
        do_start(1'b0, 1'b0, 24'hABCDEF);
        drive_s(1'b1, 1'b0);
        start    = 1'b1;
        start_tx = 1'b1;
        drive_s(1'b0, 1'b0);
        start    = 1'b0;
        drive_s(1'b1, 1'b1);
        @(negedge aclk);
        n_cmp++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0 || busy !== 1'b1) begin
            n_mis++;
            $display("FAIL start_ignored: s_tready=%0b m_tvalid=%0b busy=%0b, required 1 0 1",
                     s_tready, m_tvalid, busy);
        end
        @(posedge aclk);
        #1;
        for (int i = 0; i < 5; i++) drive_s(i[0], 1'b0);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        check_idle_outputs("areset_mid_crc");
        check_drained("start_busy");
    endtask

    initial begin
        areset        = 1'b1;
        start         = 1'b0;
        start_tx      = 1'b0;
        start_use_def = 1'b0;
        crc_init      = '0;
        abort         = 1'b0;
        s_tdata       = 1'b0;
        s_tvalid      = 1'b0;
        s_tlast       = 1'b0;

        test_reset();
        test_tx_single();
        test_rx_single(1'b0);
        test_rx_single(1'b1);
        test_back_pressure();
        test_abort();
        test_start_busy_areset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
